// File: rtl/cnn_stream_pkg.sv
// Shared constants for the CNN streaming path (feature-map sides, pixel format, streamer FSM states).
package cnn_stream_pkg;
   localparam int unsigned DIM_112   = 112;
   localparam int unsigned DIM_56    = 56;
   localparam int unsigned DIM_28    = 28;
   localparam int unsigned PIX_W     = 14;
   localparam int unsigned FRAC_BITS = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } stream_state_t;
endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry skid FIFO; the head entry is presented combinationally, occupancy exported for credit flow.
module stream_skid_fifo #(
   parameter int unsigned WIDTH = 16
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             head_valid,
   output logic [1:0]       occupancy
);
   logic [WIDTH-1:0] slot [2];
   logic             wr_ptr;
   logic             rd_ptr;
   logic [1:0]       count;
   logic             pop_ok;

   assign pop_ok     = pop && (count != 2'd0);
   assign head_data  = slot[rd_ptr];
   assign head_valid = (count != 2'd0);
   assign occupancy  = count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot[0] <= '0;
         slot[1] <= '0;
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= '0;
      end else begin
         if (push) begin
            slot[wr_ptr] <= push_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (pop_ok)
            rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop_ok};
      end
   end
endmodule

// File: rtl/padded_pixel_streamer.sv
// Streams a CxNxN feature map from SRAM as a zero-padded (N+2)x(N+2) raster per channel.
// Optional PADDED_STREAMER_STALL_CNT_EN adds a saturating stall_cnt output.
module padded_pixel_streamer
   import cnn_stream_pkg::*;
#(
   parameter int unsigned BITSIZE = PIX_W,
   parameter int unsigned MAX_DIM = DIM_112,
   parameter int unsigned PADDING = 1,
   parameter int unsigned ADDR_W  = 20,
   parameter int unsigned CH_W    = 10
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [6:0]         layer_size,
   input  logic [CH_W-1:0]    num_channels,
   input  logic [ADDR_W-1:0]  base_addr,
   output logic               mem_rd_en,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic [BITSIZE-1:0] mem_rd_data,
   output logic [BITSIZE-1:0] pix_out,
   output logic               pix_valid,
   input  logic               pix_ready,
   output logic               frame_done,
   output logic               layer_done,
   output logic               busy
`ifdef PADDED_STREAMER_STALL_CNT_EN
   ,
   output logic [31:0]        stall_cnt
`endif
);
   localparam int unsigned CNT_W = $clog2(MAX_DIM + 2);

   stream_state_t      state, state_nxt;
   logic [6:0]         n;
   logic [CNT_W-1:0]   n_last, row, col;
   logic [CH_W-1:0]    ch, ch_last;
   logic [ADDR_W-1:0]  ptr;
   logic               stg_v, stg_pad, stg_lof, stg_lol;
   logic               legal, start_ok, issue, can_issue, accept;
   logic               coord_pad, coord_lof, coord_lol;
   logic [1:0]         occ;
   logic               head_v;
   logic [BITSIZE+1:0] head, push_entry;
   logic [BITSIZE-1:0] push_pix;

   assign legal    = ((layer_size == 7'(DIM_112)) || (layer_size == 7'(DIM_56)) ||
                      (layer_size == 7'(DIM_28))) && (num_channels != '0);
   assign start_ok = (state == IDLE) && start && legal;
   assign accept   = head_v && pix_ready;

   // The entry accepted this cycle frees its slot, which keeps 1 pixel/clk with ready high.
   assign can_issue = ({1'b0, occ} + {2'b0, stg_v}) < (3'd2 + {2'b0, accept});

   assign n_last    = CNT_W'(n) + CNT_W'(2 * PADDING - 1);
   assign coord_pad = (row == '0) || (col == '0) || (row == n_last) || (col == n_last);
   assign coord_lof = (row == n_last) && (col == n_last);
   assign coord_lol = coord_lof && (ch == ch_last);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   // Pixel (0,0) is always a pad, so it is issued in the start cycle itself.
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         IDLE: begin
            if (start_ok) begin
               issue     = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (can_issue) begin
               issue = 1'b1;
               if (coord_lol) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (accept && head[0]) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign mem_rd_en = issue && !coord_pad;
   assign mem_addr  = ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         n       <= '0;
         ch_last <= '0;
         ch      <= '0;
         row     <= '0;
         col     <= '0;
         ptr     <= '0;
         stg_v   <= 1'b0;
         stg_pad <= 1'b0;
         stg_lof <= 1'b0;
         stg_lol <= 1'b0;
      end else begin
         stg_v   <= issue;
         stg_pad <= coord_pad;
         stg_lof <= coord_lof;
         stg_lol <= coord_lol;
         if (start_ok) begin
            n       <= layer_size;
            ch_last <= num_channels - CH_W'(1);
            ch      <= '0;
            ptr     <= base_addr;
         end else if (mem_rd_en) begin
            ptr <= ptr + ADDR_W'(1);
         end
         if (issue) begin
            if (col == n_last) begin
               col <= '0;
               if (row == n_last) begin
                  row <= '0;
                  ch  <= ch + CH_W'(1);
               end else begin
                  row <= row + CNT_W'(1);
               end
            end else begin
               col <= col + CNT_W'(1);
            end
         end
      end
   end

   assign push_pix   = stg_pad ? '0 : mem_rd_data;
   assign push_entry = {push_pix, stg_lof, stg_lol};

   stream_skid_fifo #(.WIDTH(BITSIZE + 2)) u_skid (
      .clk        (clk),
      .rst        (rst),
      .push       (stg_v),
      .push_data  (push_entry),
      .pop        (accept),
      .head_data  (head),
      .head_valid (head_v),
      .occupancy  (occ)
   );

   assign pix_out    = head[BITSIZE+1:2];
   assign pix_valid  = head_v;
   assign frame_done = accept && head[1];
   assign layer_done = accept && head[0];
   assign busy       = (state != IDLE);

`ifdef PADDED_STREAMER_STALL_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_cnt <= '0;
      else if (start_ok)
         stall_cnt <= '0;
      else if (head_v && !pix_ready && (stall_cnt != '1))
         stall_cnt <= stall_cnt + 32'd1;
   end
`endif
endmodule

// File: doc/padded_pixel_streamer.md
Name: padded_pixel_streamer

Overview:
- Transmit side of the 3x3 line-buffer window FIFO.
- Reads a feature map, one channel at a time, from the activation SRAM (1-cycle synchronous read).
- Emits the zero-padded raster stream, (N+2)x(N+2) per channel, as pixel + write-enable into the window FIFO.
- Pulses frame_done per channel (drives the FIFO window_done) and layer_done after the last channel; honours downstream backpressure.

Parameters:
- BITSIZE, 14, pixel width (Q7.7 signed).
- MAX_DIM, 112, largest supported feature-map side N.
- PADDING, 1, zero border width; fixed at 1 in this revision.
- ADDR_W, 20, SRAM word-address width.
- CH_W, 10, channel-count width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low.
- start  in  1  single-cycle pulse; begins a layer when idle.
- layer_size  in  7  N; legal values 112, 56, 28.
- num_channels  in  CH_W  channel count C; 0 is illegal.
- base_addr  in  ADDR_W  word address of channel 0, pixel (0,0).
- mem_rd_en  out  1  SRAM read strobe.
- mem_addr  out  ADDR_W  SRAM read address.
- mem_rd_data  in  BITSIZE  SRAM data, valid exactly 1 cycle after mem_rd_en.
- pix_out  out  BITSIZE  padded pixel to the window FIFO.
- pix_valid  out  1  pix_out valid; maps to the FIFO wr_en when pix_ready=1.
- pix_ready  in  1  downstream accept.
- frame_done  out  1  1-cycle pulse, same cycle as acceptance of the last padded pixel of a channel.
- layer_done  out  1  1-cycle pulse, coincides with frame_done of the last channel.
- busy  out  1  high from the accepted start until after the layer_done cycle.

Behaviour:
- Reset: all outputs 0, FSM IDLE, counters, address pointer and skid buffer cleared.
- Reset mid-layer aborts immediately; no done pulses are issued.
- FSM states:
  - IDLE: start with legal N and C≠0 latches N, C and base_addr into ptr, then goes to RUN. Illegal start is ignored and busy stays 0.
  - RUN: generator walks col 0..N+1 inner, row 0..N+1 outer, channel 0..C-1.
  - DRAIN: entered after the last coordinate is issued; waits until the skid buffer is empty and in-flight=0, then returns to IDLE.
- start while busy is ignored.
- Pad coordinate: row or col equal to 0 or N+1. It enters the skid buffer as literal 0, with no SRAM read.
- Interior coordinate: asserts mem_rd_en with mem_addr=ptr, then ptr increments. The data enters the skid buffer in the next cycle.
- ptr runs contiguously across channels (channel stride N*N).
- Skid buffer:
  - 2-entry FIFO; the head drives pix_out/pix_valid.
  - Entries carry {data, last_of_frame, last_of_layer}.
  - Issue rule: a coordinate advances only when occupancy + inflight < 2, so no read data is ever dropped.
  - Throughput is 1 pixel/clk with pix_ready held high.
- Latency: start to first pix_valid = 2 clk; the first pixel is a pad, so it is 0.
- Backpressure: pix_valid/pix_out are held stable while pix_ready=0. pix_valid never drops without acceptance.
- Done pulses:
  - frame_done fires on acceptance of the head entry with last_of_frame set.
  - layer_done fires likewise with last_of_layer set.
  - busy falls in the cycle after layer_done.
- Per channel: exactly (N+2)^2 pixels accepted and N^2 reads issued.
- Arithmetic: ptr addition wraps modulo 2^ADDR_W; no overflow flag.
- Counters are sized by $clog2(MAX_DIM+2).
- layer_size and num_channels are only sampled at start.

Optional Feature:
- Macro: PADDED_STREAMER_STALL_CNT_EN.
- Defined: adds output stall_cnt [31:0], counting cycles with pix_valid=1 and pix_ready=0.
  - Cleared on reset and on accepted start; saturates at 2^32-1.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package cnn_stream_pkg holds:
  - localparams DIM_112=112, DIM_56=56, DIM_28=28;
  - pixel width 14, FRAC_BITS 7;
  - FSM state encoding (IDLE, RUN, DRAIN).
- The window FIFO imports the same DIM constants.
- One sub-module: stream_skid_fifo (2-entry, parameterised width, with occupancy output).

Test Plan:
- N=28, C=1, pix_ready=1, mem[i]=i+1:
  - exactly 900 valid pixels;
  - pixels 0..30 are 0, pixel 31 is 1, pixel 58 is 28, pixel 59 is 0, pixel 868 is 784;
  - 784 reads;
  - frame_done and layer_done both at pixel 899; busy low one cycle later.
- N=56, C=3, base_addr=1000:
  - three frame_done pulses, 3364 pixels apart;
  - channel 2 first read at address 1000+2*3136=7272;
  - layer_done only with the third frame_done.
- Random pix_ready (50% duty) with N=28, C=2:
  - scoreboard matches the ready=1 run bit-exactly;
  - pix_out stable while stalled;
  - no dropped or duplicated pixels.
- Illegal layer_size=30 and num_channels=0 starts: busy stays 0, no mem_rd_en; a subsequent legal start works.
- rst asserted at pixel 400 of N=112: outputs 0 asynchronously; no done pulses; a fresh start from address base_addr emits a pad pixel first.
- start pulsed mid-layer: ignored; pixel count and done timing unchanged. With the macro defined, stall_cnt equals the count of stall cycles.
